// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/flush bundle between the decode stage and the register scoreboard.
// The decode stage drives the request side; the scoreboard answers with the hazard and occupancy outputs.
interface reg_scoreboard_if;
  logic        issue_valid;
  logic        issue_wen;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;
  logic        issue_fire;
  logic [31:0] pending;
  logic [6:0]  inflight;
  logic        err_underflow;

  modport master (
    output issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
           rs1_used, rs2_used, wb_valid, wb_rd, flush,
    input  stall, issue_fire, pending, inflight, err_underflow
  );

  modport slave (
    input  issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
           rs1_used, rs2_used, wb_valid, wb_rd, flush,
    output stall, issue_fire, pending, inflight, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: a 2-bit in-flight producer count per architectural register,
// a combinational issue stall, and a sticky writeback-underflow flag.
module reg_scoreboard (
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  sb
);

  logic [1:0] cnt_q [32];
  logic [1:0] cnt_d [32];
  logic [6:0] inflight_q, inflight_d;
  logic       err_q, err_d;

  logic [1:0] c_rs1, c_rs2, c_rd, c_wb;
  logic       rs1_haz, rs2_haz, full_haz;
  logic       stall, fire, inc_en, dec_en, under;

  always_comb begin
    c_rs1 = cnt_q[sb.issue_rs1];
    c_rs2 = cnt_q[sb.issue_rs2];
    c_rd  = cnt_q[sb.issue_rd];
    c_wb  = cnt_q[sb.wb_rd];

    // A retiring last producer in the same cycle releases the source hazard.
    rs1_haz  = sb.rs1_used && (sb.issue_rs1 != 5'd0) && (c_rs1 != 2'd0) &&
               !(sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && (c_rs1 == 2'd1));
    rs2_haz  = sb.rs2_used && (sb.issue_rs2 != 5'd0) && (c_rs2 != 2'd0) &&
               !(sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && (c_rs2 == 2'd1));
    full_haz = sb.issue_wen && (sb.issue_rd != 5'd0) && (c_rd == 2'd3) &&
               !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));

    stall  = sb.issue_valid && (rs1_haz || rs2_haz || full_haz) && !sb.flush;
    fire   = sb.issue_valid && !stall;
    inc_en = fire && sb.issue_wen && (sb.issue_rd != 5'd0);
    dec_en = sb.wb_valid && (sb.wb_rd != 5'd0) && (c_wb != 2'd0);
    under  = sb.wb_valid && (sb.wb_rd != 5'd0) && (c_wb == 2'd0);
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb.flush || r == 0) begin
        cnt_d[r] = 2'd0;
      end else begin
        if (inc_en && (sb.issue_rd == r[4:0]) && !(dec_en && (sb.wb_rd == r[4:0])))
          cnt_d[r] = cnt_q[r] + 2'd1;
        else if (dec_en && (sb.wb_rd == r[4:0]) && !(inc_en && (sb.issue_rd == r[4:0])))
          cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
    inflight_d = sb.flush ? 7'd0 : (inflight_q + {6'd0, inc_en} - {6'd0, dec_en});
    err_d      = err_q | under;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= 2'd0;
      inflight_q <= 7'd0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_pend
      assign sb.pending[gi] = (cnt_q[gi] != 2'd0);
    end
  endgenerate

  assign sb.stall         = stall;
  assign sb.issue_fire    = fire;
  assign sb.inflight      = inflight_q;
  assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against a per-register count model.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_bus ();

  reg_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_bus)
  );

  int m_cnt [32];
  bit m_err;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] != 0);
    return p;
  endfunction

  function automatic int m_inflight();
    int s = 0;
    for (int r = 1; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  // One clock of stimulus: drive after the falling edge, check mid-cycle, advance the model at the rising edge.
  task automatic step(input bit v, input bit wen, input int rd, input int rs1, input int rs2,
                      input bit u1, input bit u2, input bit wbv, input int wbrd, input bit fl,
                      input string tag);
    bit h1, h2, hf, exp_stall, exp_fire;
    @(negedge clk);
    sb_bus.issue_valid = v;   sb_bus.issue_wen = wen;
    sb_bus.issue_rd = 5'(rd); sb_bus.issue_rs1 = 5'(rs1); sb_bus.issue_rs2 = 5'(rs2);
    sb_bus.rs1_used = u1;     sb_bus.rs2_used = u2;
    sb_bus.wb_valid = wbv;    sb_bus.wb_rd = 5'(wbrd);  sb_bus.flush = fl;
    h1 = u1 && rs1 != 0 && m_cnt[rs1] != 0 && !(wbv && wbrd == rs1 && m_cnt[rs1] == 1);
    h2 = u2 && rs2 != 0 && m_cnt[rs2] != 0 && !(wbv && wbrd == rs2 && m_cnt[rs2] == 1);
    hf = wen && rd != 0 && m_cnt[rd] == 3 && !(wbv && wbrd == rd);
    exp_stall = v && (h1 || h2 || hf) && !fl;
    exp_fire  = v && !exp_stall;
    #1;
    $display("[%0t] %s v=%0d wen=%0d rd=%0d rs=%0d/%0d wb=%0d/%0d fl=%0d stall=%0d infl=%0d",
             $time, tag, v, wen, rd, rs1, rs2, wbv, wbrd, fl, sb_bus.stall, sb_bus.inflight);
    chk({tag, "_stall"}, 64'(sb_bus.stall), 64'(exp_stall));
    chk({tag, "_fire"},  64'(sb_bus.issue_fire), 64'(exp_fire));
    chk({tag, "_pend"},  64'(sb_bus.pending), 64'(m_pending()));
    chk({tag, "_infl"},  64'(sb_bus.inflight), 64'(m_inflight()));
    chk({tag, "_err"},   64'(sb_bus.err_underflow), 64'(m_err));
    @(posedge clk);
    if (wbv && wbrd != 0 && m_cnt[wbrd] == 0) m_err = 1'b1;
    if (fl) begin
      model_clear();
    end else begin
      if (wbv && wbrd != 0 && m_cnt[wbrd] > 0) m_cnt[wbrd]--;
      if (exp_fire && wen && rd != 0) m_cnt[rd]++;
    end
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Reset asserted mid-cycle: outputs must drop without waiting for a clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    sb_bus.issue_valid = 1'b0; sb_bus.wb_valid = 1'b0; sb_bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("[%0t] %s reset asserted", $time, tag);
    chk({tag, "_pend"},  64'(sb_bus.pending), 64'd0);
    chk({tag, "_infl"},  64'(sb_bus.inflight), 64'd0);
    chk({tag, "_err"},   64'(sb_bus.err_underflow), 64'd0);
    chk({tag, "_stall"}, 64'(sb_bus.stall), 64'd0);
    model_clear();
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rd, rs1, rs2, wbrd;
    model_clear();
    m_err = 1'b0;
    sb_bus.issue_valid = 0; sb_bus.issue_wen = 0; sb_bus.issue_rd = 0;
    sb_bus.issue_rs1 = 0; sb_bus.issue_rs2 = 0; sb_bus.rs1_used = 0; sb_bus.rs2_used = 0;
    sb_bus.wb_valid = 0; sb_bus.wb_rd = 0; sb_bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_pend", 64'(sb_bus.pending), 64'd0);
    chk("por_infl", 64'(sb_bus.inflight), 64'd0);
    chk("por_err",  64'(sb_bus.err_underflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Producer on r5, dependent consumer stalls until writeback of r5.
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, "raw_issue");
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, "raw_dep1");
    chk("raw_stall_const", 64'(m_inflight()), 64'd1);
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, "raw_dep2");
    step(1, 0, 0, 5, 0, 1, 0, 1, 5, 0, "raw_wb");
    idle("raw_after");
    chk("raw_pend5", 64'(sb_bus.pending[5]), 64'd0);

    // Register zero is never tracked.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "x0");
    chk("x0_infl", 64'(sb_bus.inflight), 64'd0);

    // Counter saturation on r7 and release by a same-cycle writeback.
    for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, "sat_fill");
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, "sat_full");
    step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, "sat_wbrel");
    idle("sat_after");
    chk("sat_infl", 64'(sb_bus.inflight), 64'd3);

    // Same-cycle issue and writeback on r9 cancel.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "flush0");
    step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, "cancel_a");
    step(1, 1, 9, 0, 0, 0, 0, 1, 9, 0, "cancel_b");
    idle("cancel_after");
    chk("cancel_infl", 64'(sb_bus.inflight), 64'd1);

    // Underflow is sticky through flush.
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, "uf_wb");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "uf_flush");
    idle("uf_after");
    chk("uf_sticky", 64'(sb_bus.err_underflow), 64'd1);

    // Flush overrides a simultaneous issue.
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, "fl_p3");
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, "fl_p4");
    step(1, 1, 6, 0, 0, 0, 0, 0, 0, 1, "fl_issue6");
    idle("fl_after");
    chk("fl_pend", 64'(sb_bus.pending), 64'd0);

    step(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, "prerst");
    pulse_reset("rst_mid");
    idle("rst_clean");

    // Random traffic over a few registers so hazards and saturation recur.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        rd   = int'($urandom_range(0, 7));
        rs1  = int'($urandom_range(0, 7));
        rs2  = int'($urandom_range(0, 7));
        wbrd = int'($urandom_range(0, 7));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rd, rs1, rs2,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, wbrd, $urandom_range(0, 39) == 0, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
